pspin_cmd_router: RTL and testbench
===================================

Name: pspin_cmd_router

Overview:
- Sits directly downstream of the HPU command issue path, upstream of the per-interface command engines: host-direct (id 0), NIC outbound (id 1), eDMA (id 2).
- Takes one serialized command stream and steers each command to the interface selected by its interface-id field.
- Keeps a per-interface outstanding count for flow control.
- Merges completion responses from all interfaces back into one stream with round-robin fairness.

Parameters:
- NUM_INTF, 3, number of command interfaces.
- MAX_OUTSTANDING, 8, max in-flight commands per interface (>=1).
- CMD_W, 640, opaque command payload width.
- RESP_W, 520, opaque response payload width (command id + 512b immediate data).
- IDW, $clog2(NUM_INTF) (min 1), interface-id width.
- CNTW, $clog2(MAX_OUTSTANDING+1), counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async reset, active low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_intf_id_i  in  IDW  target interface.
- cmd_i  in  CMD_W  command payload.
- intf_valid_o  out  NUM_INTF  one-hot valid to interfaces.
- intf_ready_i  in  NUM_INTF  interface ready.
- intf_cmd_o  out  CMD_W  payload, shared by all interfaces.
- intf_resp_valid_i  in  NUM_INTF  per-interface completion valid.
- intf_resp_ready_o  out  NUM_INTF  completion accepted.
- intf_resp_i  in  NUM_INTF*RESP_W  completion payloads, interface i at [i*RESP_W +: RESP_W].
- resp_valid_o  out  1  merged completion valid.
- resp_ready_i  in  1  merged completion ready.
- resp_o  out  RESP_W  merged completion payload.
- outstanding_o  out  NUM_INTF*CNTW  per-interface in-flight counts.
- err_o  out  1  one-cycle pulse on a protocol error.
- idle_o  out  1  no command or response held, all counts zero.

Behaviour:
- Reset (async assert, sync release):
  - all valids 0, counters 0, round-robin pointer 0, err_o 0, idle_o 1.
  - Payload registers are don't-care.
- Command path: one-entry output register (cmd_q, id_q, cmd_vq).
  - reg_fire = cmd_vq & intf_ready_i[id_q].
  - cmd_ready_o = (!cmd_vq | reg_fire) & (cnt[cmd_intf_id_i] < MAX_OUTSTANDING).
  - A decrement in the same cycle is not credited to cmd_ready_o (no comb path from responses to cmd_ready_o).
  - On accept: load the register and increment cnt[id] (the slot is reserved at accept).
  - Latency accept -> intf_valid_o = 1 cycle. Back-to-back throughput 1/cycle when the target interface is ready.
  - intf_valid_o = cmd_vq ? (1<<id_q) : 0.
  - intf_cmd_o and the one-hot stay stable while valid and not ready.
- Invalid id (cmd_intf_id_i >= NUM_INTF):
  - cmd_ready_o = (!cmd_vq | reg_fire), with no capacity check.
  - Command consumed and dropped, no counter change, err_o pulses the next cycle.
- Response path: round-robin arbiter feeding a one-entry register (resp_q, resp_vq).
  - can_load = !resp_vq | resp_ready_i.
  - Grant = first i >= ptr (wrapping) with intf_resp_valid_i[i].
  - intf_resp_ready_o[i] = can_load & grant[i]; at most one bit set.
  - On a response handshake: load resp_q, set resp_vq, ptr = granted+1 mod NUM_INTF, decrement cnt[granted].
  - Pointer unchanged when nothing is granted.
  - resp_vq clears on resp_ready_i when nothing is loaded. resp_o stable while valid and not ready.
  - Latency response handshake -> resp_valid_o = 1 cycle. Full throughput 1/cycle.
- Counters:
  - Increment and decrement on the same interface in the same cycle: net unchanged.
  - A response while cnt[i] == 0: still accepted and forwarded, counter stays 0 (saturates), err_o pulses the next cycle.
  - Increment never exceeds MAX_OUTSTANDING, guaranteed by the ready gating.
- err_o: registered, 1 cycle after the causing event. The OR of the invalid-id and underflow conditions gives a single pulse.
- idle_o = !cmd_vq & !resp_vq & all counters zero (combinational from state).
- Reset mid-operation: held command and response are lost, counters cleared. Interfaces are reset together with this block.

Test Plan:
- Single command: id=1, payload A, intf_ready_i=3'b111 -> intf_valid_o=3'b010 with A 1 cycle later; outstanding[1]=1. Response from intf 1 -> resp_o matches 1 cycle after handshake, outstanding[1]=0, idle_o=1.
- Back-pressure/capacity: 8 commands to id 2 with intf_ready_i[2] pulsed as needed, no responses -> 9th command sees cmd_ready_o=0. One response from intf 2 -> cmd_ready_o=1 the next cycle.
- Stalled output: intf_ready_i[0]=0 for 5 cycles with a command held -> intf_cmd_o stable and cmd_ready_o=0. Release -> the next queued command is accepted in the same cycle as the drain.
- Round-robin: all 3 intf_resp_valid_i held high, resp_ready_i=1 -> grant order 0,1,2,0,1,2. With resp_ready_i=0 -> no intf_resp_ready_o asserted after the register fills.
- Errors: cmd_intf_id_i=3 -> accepted, no intf_valid_o, err_o pulse 1 cycle later. Response from intf 0 with outstanding[0]=0 -> forwarded, err_o pulse, count stays 0.
- Simultaneous events and reset: a command accept and a response for id 1 in the same cycle keep outstanding[1] unchanged. rst_ni asserted mid-transfer -> all valids 0 and counters 0 immediately.

Source files
------------

// File: rtl/pspin_cmd_router.sv
// Steers a serialized command stream to per-interface engines, tracks in-flight
// counts per interface, and merges completions back with round-robin fairness.
module pspin_cmd_router #(
  parameter int unsigned NUM_INTF        = 3,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CMD_W           = 640,
  parameter int unsigned RESP_W          = 520,
  parameter int unsigned IDW             = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1,
  parameter int unsigned CNTW            = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [IDW-1:0]             cmd_intf_id_i,
  input  logic [CMD_W-1:0]           cmd_i,
  output logic [NUM_INTF-1:0]        intf_valid_o,
  input  logic [NUM_INTF-1:0]        intf_ready_i,
  output logic [CMD_W-1:0]           intf_cmd_o,
  input  logic [NUM_INTF-1:0]        intf_resp_valid_i,
  output logic [NUM_INTF-1:0]        intf_resp_ready_o,
  input  logic [NUM_INTF*RESP_W-1:0] intf_resp_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [RESP_W-1:0]          resp_o,
  output logic [NUM_INTF*CNTW-1:0]   outstanding_o,
  output logic                       err_o,
  output logic                       idle_o
);

  logic [CMD_W-1:0]    cmd_q;
  logic [IDW-1:0]      id_q;
  logic                cmd_vq;
  logic [RESP_W-1:0]   resp_q;
  logic                resp_vq;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [CNTW-1:0]     cnt_q [NUM_INTF];
  logic [CNTW-1:0]     cnt_d [NUM_INTF];
  logic                err_q, err_d;

  logic                id_ok, sel_cnt_ok, reg_fire, cmd_fire, cmd_load;
  logic                can_load, resp_fire, gnt_any, underflow, cnt_zero;
  logic [NUM_INTF-1:0] gnt, inc_v, dec_v;
  logic [IDW-1:0]      gnt_idx;
  logic [RESP_W-1:0]   gnt_resp;

  assign id_ok = 32'(cmd_intf_id_i) < NUM_INTF;

  // Capacity is judged on registered counts only, so responses never reach cmd_ready_o.
  always_comb begin
    reg_fire     = 1'b0;
    sel_cnt_ok   = 1'b0;
    intf_valid_o = '0;
    for (int unsigned i = 0; i < NUM_INTF; i++) begin
      if (cmd_vq && id_q == IDW'(i)) begin
        reg_fire        = intf_ready_i[i];
        intf_valid_o[i] = 1'b1;
      end
      if (cmd_intf_id_i == IDW'(i)) sel_cnt_ok = cnt_q[i] < CNTW'(MAX_OUTSTANDING);
    end
  end

  assign cmd_ready_o = (!cmd_vq || reg_fire) && (!id_ok || sel_cnt_ok);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign cmd_load    = cmd_fire && id_ok;
  assign intf_cmd_o  = cmd_q;

  // Round-robin: scan from ptr upward first, then wrap to the low indices.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_resp = '0;
    for (int unsigned i = 0; i < NUM_INTF; i++) begin
      if (!gnt_any && 32'(ptr_q) <= i && intf_resp_valid_i[i]) begin
        gnt_any  = 1'b1;
        gnt[i]   = 1'b1;
        gnt_idx  = IDW'(i);
        gnt_resp = intf_resp_i[i*RESP_W +: RESP_W];
      end
    end
    for (int unsigned i = 0; i < NUM_INTF; i++) begin
      if (!gnt_any && intf_resp_valid_i[i]) begin
        gnt_any  = 1'b1;
        gnt[i]   = 1'b1;
        gnt_idx  = IDW'(i);
        gnt_resp = intf_resp_i[i*RESP_W +: RESP_W];
      end
    end
    ptr_d = (32'(gnt_idx) == NUM_INTF - 1) ? '0 : gnt_idx + IDW'(1);
  end

  assign can_load          = !resp_vq || resp_ready_i;
  assign resp_fire         = can_load && gnt_any;
  assign intf_resp_ready_o = can_load ? gnt : '0;
  assign resp_valid_o      = resp_vq;
  assign resp_o            = resp_q;

  always_comb begin
    underflow     = 1'b0;
    cnt_zero      = 1'b1;
    outstanding_o = '0;
    for (int unsigned i = 0; i < NUM_INTF; i++) begin
      inc_v[i] = cmd_load && cmd_intf_id_i == IDW'(i);
      dec_v[i] = resp_fire && gnt[i];
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CNTW'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] == '0) underflow = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNTW'(1);
      end
      if (cnt_q[i] != '0) cnt_zero = 1'b0;
      outstanding_o[i*CNTW +: CNTW] = cnt_q[i];
    end
    err_d = (cmd_fire && !id_ok) || underflow;
  end

  assign err_o  = err_q;
  assign idle_o = !cmd_vq && !resp_vq && cnt_zero;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_vq  <= 1'b0;
      id_q    <= '0;
      resp_vq <= 1'b0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_INTF; i++) cnt_q[i] <= '0;
    end else begin
      if (cmd_load) begin
        cmd_vq <= 1'b1;
        id_q   <= cmd_intf_id_i;
      end else if (reg_fire) begin
        cmd_vq <= 1'b0;
      end
      if (resp_fire) begin
        resp_vq <= 1'b1;
        ptr_q   <= ptr_d;
      end else if (resp_ready_i) begin
        resp_vq <= 1'b0;
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_load)  cmd_q  <= cmd_i;
    if (resp_fire) resp_q <= gnt_resp;
  end

endmodule

// File: tb/tb_pspin_cmd_router.sv
// Bench for pspin_cmd_router: directed stimulus plus a negedge reference model
// with command/response scoreboards.
module tb_pspin_cmd_router;
  localparam int N = 3, MAXO = 8, CMD_W = 640, RESP_W = 520, IDW = 2, CNTW = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [IDW-1:0]        cmd_id;
  logic [CMD_W-1:0]      cmd;
  logic [N-1:0]          intf_valid, intf_ready, intf_resp_valid, intf_resp_ready;
  logic [CMD_W-1:0]      intf_cmd;
  logic [N*RESP_W-1:0]   intf_resp;
  logic                  resp_valid, resp_ready, err, idle;
  logic [RESP_W-1:0]     resp;
  logic [N*CNTW-1:0]     outstanding;

  int checks = 0;
  int failures = 0;

  pspin_cmd_router #(.NUM_INTF(N), .MAX_OUTSTANDING(MAXO), .CMD_W(CMD_W), .RESP_W(RESP_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_intf_id_i(cmd_id), .cmd_i(cmd),
    .intf_valid_o(intf_valid), .intf_ready_i(intf_ready), .intf_cmd_o(intf_cmd),
    .intf_resp_valid_i(intf_resp_valid), .intf_resp_ready_o(intf_resp_ready), .intf_resp_i(intf_resp),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_o(resp),
    .outstanding_o(outstanding), .err_o(err), .idle_o(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CMD_W-1:0] got, input logic [CMD_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] rnd();
    logic [CMD_W-1:0] v;
    for (int i = 0; i < CMD_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Reference model, evaluated at negedge when inputs and outputs are settled
  logic              m_cvq, m_rvq, m_err;
  int                m_id, m_ptr;
  int                m_cnt [N];
  logic [CMD_W-1:0]  cq [$];
  logic [RESP_W-1:0] rq [$];
  int                gnt_log [$];

  always @(negedge clk) begin
    logic              c_fire, id_ok, exp_crdy, can_load, new_err, zero, inc, dec;
    logic [N-1:0]      exp_rrdy;
    logic [N*CNTW-1:0] exp_out;
    logic [CMD_W-1:0]  cexp;
    logic [RESP_W-1:0] rexp;
    int                g, id;
    if (!rst_n) begin
      m_cvq = 0; m_rvq = 0; m_err = 0; m_id = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      cq.delete(); rq.delete();
    end else begin
      exp_out = '0;
      zero = 1;
      for (int i = 0; i < N; i++) begin
        exp_out[i*CNTW +: CNTW] = CNTW'(m_cnt[i]);
        if (m_cnt[i] != 0) zero = 0;
      end
      check("m_intf_valid", intf_valid, m_cvq ? (1 << m_id) : 0);
      check("m_outstanding", outstanding, exp_out);
      check("m_resp_valid", resp_valid, m_rvq);
      check("m_err", err, m_err);
      check("m_idle", idle, !m_cvq && !m_rvq && zero);

      id = int'(cmd_id);
      id_ok = id < N;
      c_fire = m_cvq && intf_ready[m_id];
      exp_crdy = (!m_cvq || c_fire) && (!id_ok || m_cnt[id] < MAXO);
      check("m_cmd_ready", cmd_ready, exp_crdy);
      can_load = !m_rvq || resp_ready;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && intf_resp_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rrdy = (can_load && g >= 0) ? N'(1 << g) : '0;
      check("m_resp_ready", intf_resp_ready, exp_rrdy);

      if (c_fire) begin
        if (cq.size() == 0) check("sb_cmd_empty", 1, 0);
        else begin cexp = cq.pop_front(); check("sb_intf_cmd", intf_cmd, cexp); end
      end
      if (m_rvq && resp_ready) begin
        if (rq.size() == 0) check("sb_resp_empty", 1, 0);
        else begin rexp = rq.pop_front(); check("sb_resp", resp, rexp); end
      end

      new_err = cmd_valid && exp_crdy && !id_ok;
      for (int i = 0; i < N; i++) begin
        inc = cmd_valid && exp_crdy && id_ok && id == i;
        dec = exp_rrdy[i];
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc) begin
          if (m_cnt[i] == 0) new_err = 1;
          else m_cnt[i]--;
        end
      end
      if (cmd_valid && exp_crdy && id_ok) begin
        m_cvq = 1; m_id = id; cq.push_back(cmd);
      end else if (c_fire) m_cvq = 0;
      if (exp_rrdy != 0) begin
        m_rvq = 1; rq.push_back(intf_resp[g*RESP_W +: RESP_W]);
        m_ptr = (g + 1) % N; gnt_log.push_back(int'(exp_rrdy));
      end else if (resp_ready) m_rvq = 0;
      m_err = new_err;
    end
  end

  // All tasks start and end one time unit after a rising edge
  task automatic send_cmd(input int id, input logic [CMD_W-1:0] p);
    int n = 0;
    cmd_valid = 1; cmd_id = IDW'(id); cmd = p;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) check("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic send_resp(input int i, input logic [RESP_W-1:0] p);
    int n = 0;
    intf_resp_valid[i] = 1; intf_resp[i*RESP_W +: RESP_W] = p;
    @(negedge clk);
    while (!intf_resp_ready[i] && n < 50) begin @(negedge clk); n++; end
    if (!intf_resp_ready[i]) check("resp_timeout", 0, 1);
    @(posedge clk); #1;
    intf_resp_valid[i] = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CMD_W-1:0]  a, b, c;
    logic [RESP_W-1:0] r, p0, p1, p2;
    int n;
    int rr_exp [6] = '{1, 2, 4, 1, 2, 4};
    rst_n = 0; cmd_valid = 0; cmd_id = '0; cmd = '0; intf_ready = 3'b111;
    intf_resp_valid = '0; intf_resp = '0; resp_ready = 1;
    tick(3);
    rst_n = 1;
    check("rst_idle", idle, 1);
    check("rst_out", outstanding, 0);
    check("rst_ivalid", intf_valid, 0);
    check("rst_rvalid", resp_valid, 0);
    check("rst_err", err, 0);

    // single command and its completion
    a = rnd(); c = rnd(); r = c[RESP_W-1:0];
    send_cmd(1, a);
    check("t1_onehot", intf_valid, 3'b010);
    check("t1_cmd", intf_cmd, a);
    check("t1_cnt", outstanding[CNTW +: CNTW], 1);
    send_resp(1, r);
    check("t1_rvalid", resp_valid, 1);
    check("t1_resp", resp, r);
    check("t1_cnt0", outstanding[CNTW +: CNTW], 0);
    tick(1);
    check("t1_idle", idle, 1);

    // capacity on interface 2
    for (int k = 0; k < MAXO; k++) send_cmd(2, rnd());
    check("cap_cnt", outstanding[2*CNTW +: CNTW], MAXO);
    cmd_valid = 1; cmd_id = 2; cmd = rnd();
    @(negedge clk);
    check("cap_full", cmd_ready, 0);
    @(posedge clk); #1;
    c = rnd(); intf_resp_valid[2] = 1; intf_resp[2*RESP_W +: RESP_W] = c[RESP_W-1:0];
    @(negedge clk);
    check("cap_nocredit", cmd_ready, 0);
    check("cap_rrdy", intf_resp_ready, 3'b100);
    @(posedge clk); #1;
    intf_resp_valid = '0;
    @(negedge clk);
    check("cap_release", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;

    // stalled output register on interface 0
    intf_ready = 3'b110;
    b = rnd(); c = rnd();
    send_cmd(0, b);
    cmd_valid = 1; cmd_id = 0; cmd = c;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_rdy", cmd_ready, 0);
      check("stall_cmd", intf_cmd, b);
      check("stall_vld", intf_valid, 3'b001);
      @(posedge clk); #1;
    end
    intf_ready = 3'b111;
    @(negedge clk);
    check("drain_acc", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    check("drain_next", intf_cmd, c);

    // round-robin with all interfaces requesting
    tick(1);
    gnt_log.delete();
    p0 = rnd(); p1 = rnd(); p2 = rnd();
    intf_resp = {p2, p1, p0}; intf_resp_valid = 3'b111; resp_ready = 1;
    n = 0;
    while (gnt_log.size() < 6 && n < 20) begin @(posedge clk); n++; end
    #1;
    resp_ready = 0;
    check("rr_count", gnt_log.size(), 6);
    for (int k = 0; k < 6 && k < gnt_log.size(); k++) check("rr_order", gnt_log[k], rr_exp[k]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rr_hold", intf_resp_ready, 0);
    end
    @(posedge clk); #1;
    intf_resp_valid = '0; resp_ready = 1;
    tick(1);

    // invalid id and response underflow
    send_cmd(3, rnd());
    check("inv_vld", intf_valid, 0);
    check("inv_err", err, 1);
    tick(1);
    check("inv_err_clr", err, 0);
    c = rnd(); r = c[RESP_W-1:0];
    send_resp(0, r);
    check("uf_err", err, 1);
    check("uf_resp", resp, r);
    check("uf_cnt", outstanding[0 +: CNTW], 0);
    tick(1);

    // simultaneous increment and decrement on interface 1
    send_cmd(1, rnd());
    tick(1);
    cmd_valid = 1; cmd_id = 1; cmd = rnd();
    c = rnd(); intf_resp_valid[1] = 1; intf_resp[RESP_W +: RESP_W] = c[RESP_W-1:0];
    @(negedge clk);
    check("sim_crdy", cmd_ready, 1);
    check("sim_rrdy", intf_resp_ready, 3'b010);
    @(posedge clk); #1;
    cmd_valid = 0; intf_resp_valid = '0;
    check("sim_cnt", outstanding[CNTW +: CNTW], 1);
    check("sim_err", err, 0);

    // drain everything outstanding
    send_resp(1, rnd());
    for (int k = 0; k < 6; k++) send_resp(2, rnd());
    tick(2);
    check("drain_idle", idle, 1);

    // reset while a command and a response are held
    intf_ready = 3'b011;
    send_cmd(2, rnd());
    resp_ready = 0;
    send_resp(0, rnd());
    rst_n = 0;
    #1;
    check("rst_mid_ivalid", intf_valid, 0);
    check("rst_mid_rvalid", resp_valid, 0);
    check("rst_mid_out", outstanding, 0);
    check("rst_mid_idle", idle, 1);
    tick(2);
    rst_n = 1; intf_ready = 3'b111; resp_ready = 1;
    a = rnd();
    send_cmd(0, a);
    check("post_rst_vld", intf_valid, 3'b001);
    check("post_rst_cmd", intf_cmd, a);
    tick(3);
    check("sb_empty", cq.size() + rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
